// File: rtl/int_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_arbiter_pkg
//  Description : Shared constants and FSM state encoding for the interrupt
//                arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package int_arbiter_pkg;

    // Number of interrupt sources; the CPU grant bus is fixed at four lines.
    localparam int NUM_SRC = 4;

    // Arbiter handshake states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        ACKED = 2'b10
    } arb_state_t;

endpackage : int_arbiter_pkg
`default_nettype wire

// File: rtl/int_arbiter_prio_enc4.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc4
//  Description : 4-bit fixed-priority encoder. Returns the lowest set bit as
//                a one-hot vector (bit 0 highest priority) plus a valid flag.
//                Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module prio_enc4 (
    input  logic [3:0] req,
    output logic [3:0] onehot,
    output logic       valid
);

    // Isolate the lowest set bit; two's-complement trick keeps it one-hot.
    always_comb begin
        onehot = req & (~req + 4'd1);
        valid  = |req;
    end

endmodule : prio_enc4
`default_nettype wire

// File: rtl/int_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : int_arbiter
//  Description : Edge-detecting interrupt arbiter. Latches rising edges of the
//                peripheral interrupt lines into a pending register, then
//                presents the highest-priority enabled pending source to the
//                CPU with a registered Ireq/gntInt pair and an Iack handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module int_arbiter #(
    parameter int NUM_SRC = int_arbiter_pkg::NUM_SRC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] int_en,
    input  logic               Iack,
    output logic               Ireq,
    output logic [NUM_SRC-1:0] gntInt,
    output logic [NUM_SRC-1:0] pending_o
);

    import int_arbiter_pkg::*;

    arb_state_t         state;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] pending;
    logic               armed;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] enc_onehot;
    logic               enc_valid;

    // Edge detect, eligibility and ack-clear mask. 'armed' suppresses the
    // first cycle after reset so a line held high through reset (with
    // irq_prev forced to 0) is not mistaken for a fresh edge.
    always_comb begin
        rise     = irq_src & ~irq_prev & {NUM_SRC{armed}};
        eligible = pending & int_en;
        clr      = '0;
        if (state == REQ && Iack) begin
            clr = gntInt;
        end
    end

    prio_enc4 u_prio_enc4 (
        .req    (eligible),
        .onehot (enc_onehot),
        .valid  (enc_valid)
    );

    // Handshake FSM with registered Ireq/gntInt, plus the pending register
    // where a new edge overrides a same-cycle acknowledge clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= '0;
            irq_prev <= '0;
            armed    <= 1'b0;
            Ireq     <= 1'b0;
            gntInt   <= '0;
        end else begin
            irq_prev <= irq_src;
            armed    <= 1'b1;
            pending  <= (pending & ~clr) | rise;
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        state  <= REQ;
                        Ireq   <= 1'b1;
                        gntInt <= enc_onehot;
                    end
                end
                REQ: begin
                    if (Iack) begin
                        state  <= ACKED;
                        Ireq   <= 1'b0;
                        gntInt <= '0;
                    end
                end
                ACKED: begin
                    if (!Iack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    Ireq   <= 1'b0;
                    gntInt <= '0;
                end
            endcase
        end
    end

    assign pending_o = pending;

endmodule : int_arbiter
`default_nettype wire

// File: tb/tb_int_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_arbiter
//  Description : Directed self-checking bench for int_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_int_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src;
    logic [3:0] int_en;
    logic       Iack;
    logic       Ireq;
    logic [3:0] gntInt;
    logic [3:0] pending_o;

    int checks   = 0;
    int failures = 0;

    int_arbiter #(.NUM_SRC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .int_en    (int_en),
        .Iack      (Iack),
        .Ireq      (Ireq),
        .gntInt    (gntInt),
        .pending_o (pending_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ireq_e,
                              input logic [3:0] gnt_e, input logic [3:0] pend_e);
        check({tag, ".Ireq"},    {31'd0, Ireq}, {31'd0, ireq_e});
        check({tag, ".gntInt"},  {28'd0, gntInt}, {28'd0, gnt_e});
        check({tag, ".pending"}, {28'd0, pending_o}, {28'd0, pend_e});
    endtask

    // Output invariants checked every cycle on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("inv.onehot", {31'd0, $onehot0(gntInt)}, 32'd1);
            check("inv.ireq_gnt", {31'd0, (Ireq && gntInt == 4'd0)}, 32'd0);
        end
    end

    initial begin
        reset = 1'b1; irq_src = 4'h0; int_en = 4'h0; Iack = 1'b0;
        step(); step();
        expect_out("reset", 1'b0, 4'h0, 4'h0);
        reset = 1'b0;
        step();

        // Single source
        int_en = 4'hF; irq_src = 4'b0100;
        step(); expect_out("single.pend", 1'b0, 4'h0, 4'b0100);
        irq_src = 4'h0;
        step(); expect_out("single.grant", 1'b1, 4'b0100, 4'b0100);
        step(); expect_out("single.hold", 1'b1, 4'b0100, 4'b0100);
        Iack = 1'b1;
        step(); expect_out("single.ack", 1'b0, 4'h0, 4'h0);
        Iack = 1'b0;
        step(); expect_out("single.idle", 1'b0, 4'h0, 4'h0);

        // Priority, plus grant stability while enables drop
        irq_src = 4'b1010;
        step(); expect_out("prio.pend", 1'b0, 4'h0, 4'b1010);
        irq_src = 4'h0;
        step(); expect_out("prio.first", 1'b1, 4'b0010, 4'b1010);
        int_en = 4'h0;
        step(); expect_out("prio.stable", 1'b1, 4'b0010, 4'b1010);
        int_en = 4'hF; Iack = 1'b1;
        step(); expect_out("prio.ack1", 1'b0, 4'h0, 4'b1000);
        Iack = 1'b0;
        step(); expect_out("prio.idle", 1'b0, 4'h0, 4'b1000);
        step(); expect_out("prio.second", 1'b1, 4'b1000, 4'b1000);
        Iack = 1'b1;
        step(); expect_out("prio.ack2", 1'b0, 4'h0, 4'h0);
        Iack = 1'b0;
        step();

        // Masking, and Iack ignored in IDLE
        int_en = 4'b1110; irq_src = 4'b0001;
        step(); irq_src = 4'h0;
        step(); expect_out("mask.held", 1'b0, 4'h0, 4'b0001);
        Iack = 1'b1;
        step(); expect_out("mask.iack_idle", 1'b0, 4'h0, 4'b0001);
        Iack = 1'b0; int_en = 4'hF;
        step(); expect_out("mask.grant", 1'b1, 4'b0001, 4'b0001);
        Iack = 1'b1;
        step(); Iack = 1'b0;
        step(); expect_out("mask.done", 1'b0, 4'h0, 4'h0);

        // Set wins over same-cycle clear
        irq_src = 4'b0010;
        step(); irq_src = 4'h0;
        step(); expect_out("setwin.grant", 1'b1, 4'b0010, 4'b0010);
        Iack = 1'b1; irq_src = 4'b0010;
        step(); expect_out("setwin.ack", 1'b0, 4'h0, 4'b0010);
        Iack = 1'b0; irq_src = 4'h0;
        step(); expect_out("setwin.idle", 1'b0, 4'h0, 4'b0010);
        step(); expect_out("setwin.regrant", 1'b1, 4'b0010, 4'b0010);
        Iack = 1'b1;
        step(); expect_out("setwin.ack2", 1'b0, 4'h0, 4'h0);
        Iack = 1'b0;
        step();

        // Reset mid-request with the source held high
        irq_src = 4'b0100;
        step(); step(); expect_out("rst.req", 1'b1, 4'b0100, 4'b0100);
        reset = 1'b1;
        step(); expect_out("rst.drop", 1'b0, 4'h0, 4'h0);
        reset = 1'b0;
        step(); step(); step();
        expect_out("rst.noreq", 1'b0, 4'h0, 4'h0);
        irq_src = 4'h0;
        step();

        // Stuck Iack keeps the FSM in ACKED
        irq_src = 4'b0101;
        step(); irq_src = 4'h0;
        step(); expect_out("stuck.grant", 1'b1, 4'b0001, 4'b0101);
        Iack = 1'b1;
        step(); expect_out("stuck.ack", 1'b0, 4'h0, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            step(); expect_out("stuck.held", 1'b0, 4'h0, 4'b0100);
        end
        Iack = 1'b0;
        step(); expect_out("stuck.idle", 1'b0, 4'h0, 4'b0100);
        step(); expect_out("stuck.next", 1'b1, 4'b0100, 4'b0100);
        Iack = 1'b1;
        step(); expect_out("stuck.final", 1'b0, 4'h0, 4'h0);
        Iack = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_int_arbiter
`default_nettype wire
